sha256_w_sched_serializer: RTL and testbench

Consumer-side counterpart to the pipelined W-memory stages. It accepts one 512-bit padded message block through a valid/ready handshake and streams the full 64-word SHA-256 message schedule W0..W63, one word per accepted beat. The compression-round datapath reads this stream. A 16-word sliding window regenerates W16..W63 on the fly using the complete recurrence σ1 + W[t-7] + σ0 + W[t-16].

---
 rtl/sha256_w_sched_serializer.sv | 54 +++++
 tb/tb_sha256_w_sched_serializer.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/sha256_w_sched_serializer.sv
// sha256_w_sched_serializer: loads one 512-bit block and streams W0..W63 over a valid/ready handshake,
// regenerating W16..W63 from a 16-word sliding window.
module sha256_w_sched_serializer (
   input  logic         CLK,
   input  logic         RST,
   input  logic         blk_valid,
   output logic         blk_ready,
   input  logic [511:0] block_in,
   output logic         w_valid,
   input  logic         w_ready,
   output logic [31:0]  w_out,
   output logic [5:0]   w_idx,
   output logic         w_last
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_nxt;
   logic [31:0] win [16];
   logic [31:0] w_new;
   logic load, beat;
   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction
   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction
   assign load = blk_valid && blk_ready;
   assign beat = w_valid && w_ready;
   // Window slot 0 is W[t-16]; the new word lands in slot 15 as the window shifts.
   assign w_new = sig1(win[14]) + win[9] + sig0(win[1]) + win[0];
   always_ff @(posedge CLK)
      state <= RST ? IDLE : state_nxt;
   always_comb
      state_nxt = load ? RUN : (beat && w_idx == 6'd63) ? IDLE : state;
   // blk_ready is held low while RST is asserted so no block is offered during reset.
   always_comb begin
      blk_ready = (state == IDLE) && !RST;
      w_valid   = (state == RUN);
      w_last    = (state == RUN) && (w_idx == 6'd63);
      w_out     = win[0];
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int k = 0; k < 16; k++) win[k] <= '0;
         w_idx <= '0;
      end else if (load) begin
         for (int k = 0; k < 16; k++) win[k] <= block_in[511 - 32*k -: 32];
         w_idx <= '0;
      end else if (beat) begin
         for (int k = 0; k < 15; k++) win[k] <= win[k+1];
         win[15] <= w_new;
         w_idx   <= w_idx + 6'd1;
      end
   end
endmodule

// File: tb/tb_sha256_w_sched_serializer.sv
// tb_sha256_w_sched_serializer: directed stimulus with a scoreboard of expected schedule words
// built from an independent SHA-256 schedule model.
module tb_sha256_w_sched_serializer;
   logic         CLK, RST, blk_valid, blk_ready, w_valid, w_ready, w_last;
   logic [511:0] block_in;
   logic [31:0]  w_out;
   logic [5:0]   w_idx;
   int n_err = 0, n_chk = 0;
   logic [38:0] q [$];
   logic hold = 0, abc_mode = 0;
   logic [31:0] h_out;
   logic [5:0]  h_idx;
   logic        h_last;
   localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};

   sha256_w_sched_serializer dut (
      .CLK(CLK), .RST(RST), .blk_valid(blk_valid), .blk_ready(blk_ready), .block_in(block_in),
      .w_valid(w_valid), .w_ready(w_ready), .w_out(w_out), .w_idx(w_idx), .w_last(w_last)
   );

   initial CLK = 0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ss0(input logic [31:0] x);
      return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
   endfunction
   function automatic logic [31:0] ss1(input logic [31:0] x);
      return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
   endfunction
   function automatic void gen(input logic [511:0] b);
      logic [31:0] w [64];
      for (int t = 0; t < 16; t++) w[t] = b[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++) w[t] = ss1(w[t-2]) + w[t-7] + ss0(w[t-15]) + w[t-16];
      for (int t = 0; t < 64; t++) q.push_back({t == 63, 6'(t), w[t]});
   endfunction
   function automatic logic [511:0] rnd_blk();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[i*32 +: 32] = $urandom;
      return b;
   endfunction

   // Scoreboard and stall-stability monitor, sampled mid-cycle.
   always @(negedge CLK) if (!RST) begin
      if (hold) begin
         chk("hold_out", w_out, h_out);
         chk("hold_idx", w_idx, h_idx);
         chk("hold_last", w_last, h_last);
         chk("hold_valid", w_valid, 1);
      end
      hold = w_valid && !w_ready;
      h_out = w_out; h_idx = w_idx; h_last = w_last;
      if (w_valid && w_ready) begin
         if (q.size() == 0) begin
            n_chk++; n_err++;
            $error("FAIL extra_beat observed idx=%0d expected no beat", w_idx);
         end else begin
            logic [38:0] e;
            e = q.pop_front();
            chk("w_out", w_out, e[31:0]);
            chk("w_idx", w_idx, e[37:32]);
            chk("w_last", w_last, e[38]);
            if (abc_mode && w_idx == 15) chk("abc_w15", w_out, 32'h00000018);
            if (abc_mode && w_idx == 16) chk("abc_w16", w_out, 32'h61626380);
            if (abc_mode && w_idx == 17) chk("abc_w17", w_out, 32'h000F0000);
         end
      end
   end

   task automatic load(input logic [511:0] b, input bit keep, output int n);
      n = 0;
      block_in = b;
      blk_valid = 1;
      gen(b);
      while (!blk_ready && n < 200) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("load_timeout", blk_ready, 1);
      @(posedge CLK); #1;
      if (!keep) blk_valid = 0;
      chk("load_valid", w_valid, 1);
      chk("load_idx", w_idx, 0);
      chk("load_w0", w_out, b[511:480]);
   endtask

   task automatic wait_done(input bit rnd);
      int n = 0;
      while (q.size() != 0 && n < 2000) begin
         @(posedge CLK); #1;
         if (rnd) w_ready = 1'($urandom_range(0, 1));
         n++;
      end
      chk("done_timeout", q.size(), 0);
      w_ready = 1;
      chk("end_ready", blk_ready, 1);
      chk("end_valid", w_valid, 0);
   endtask

   initial begin
      int n;
      logic [511:0] b1, b2;
      RST = 1; blk_valid = 1; block_in = ABC; w_ready = 0;
      repeat (3) begin
         @(posedge CLK); #1;
         chk("rst_ready", blk_ready, 0);
         chk("rst_valid", w_valid, 0);
         chk("rst_out", w_out, 0);
         chk("rst_idx", w_idx, 0);
         chk("rst_last", w_last, 0);
      end
      RST = 0; blk_valid = 0;
      #1 chk("post_rst_ready", blk_ready, 1);
      // "abc" block, full throughput
      abc_mode = 1; w_ready = 1;
      load(ABC, 0, n);
      wait_done(0);
      // Same block under random backpressure
      load(ABC, 0, n);
      wait_done(1);
      abc_mode = 0;
      // Back-to-back blocks with blk_valid held high
      b1 = rnd_blk(); b2 = rnd_blk();
      load(b1, 1, n);
      load(b2, 0, n);
      chk("b2b_gap", n, 64);
      wait_done(0);
      // Block input changes and blk_valid pulses during RUN are ignored
      load(ABC, 0, n);
      repeat (5) begin @(posedge CLK); #1; end
      block_in = rnd_blk(); blk_valid = 1;
      repeat (3) begin @(posedge CLK); #1; end
      blk_valid = 0;
      wait_done(0);
      @(posedge CLK); #1;
      chk("no_reload", w_valid, 0);
      // Reset during the W30 beat
      load(rnd_blk(), 0, n);
      n = 0;
      while (w_idx != 6'd30 && n < 200) begin
         @(posedge CLK); #1;
         n++;
      end
      chk("w30_seen", w_idx, 30);
      RST = 1;
      @(posedge CLK); #1;
      RST = 0;
      q.delete();
      chk("midrst_valid", w_valid, 0);
      chk("midrst_idx", w_idx, 0);
      chk("midrst_last", w_last, 0);
      repeat (3) begin @(posedge CLK); #1; end
      chk("midrst_quiet", w_valid, 0);
      load(rnd_blk(), 0, n);
      wait_done(0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
